// File: rtl/rv32i_fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
// Holds the fetch FSM encoding plus the NOP and reset-PC defaults.
package rv32I_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_t;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch unit: one outstanding imem request, one-entry instruction
// register toward decode, redirect/kill handling and fault placeholders.
module rv32i_fetch_unit
  import rv32I_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC = WORD_SIZE'(DEFAULT_RESET_PC)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_imem_req_valid,
  input  logic                         i_imem_req_ready,
  output logic [WORD_SIZE-1:0]         o_imem_addr,
  input  logic                         i_imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_resp_data,
  input  logic                         i_imem_resp_err,
  output logic                         o_fetch_valid,
  input  logic                         i_decode_ready,
  output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
  output logic [WORD_SIZE-1:0]         o_fetch_pc,
  output logic                         o_fetch_fault,
  input  logic                         i_redirect_valid,
  input  logic [WORD_SIZE-1:0]         i_redirect_pc
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_W =
    INSTRUCTION_WIDTH'(RV32_NOP);

  fetch_state_t state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] fpc_q, fpc_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
  logic kill_q, kill_d;
  logic hs;
  logic mis;

  assign hs  = (state_q == ST_REQ) && i_imem_req_ready;
  assign mis = i_redirect_pc[1:0] != 2'b00;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    ir_d    = ir_q;
    kill_d  = kill_q;
    // A killed request left in flight by a misaligned redirect drains here
    if (state_q != ST_WAIT && i_imem_resp_valid) begin
      kill_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc;
          if (mis) begin
            ir_d    = NOP_W;
            fpc_d   = i_redirect_pc;
            kill_d  = hs;
            state_d = ST_FAULT;
          end else if (hs) begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (hs) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc;
          if (mis) begin
            ir_d    = NOP_W;
            fpc_d   = i_redirect_pc;
            kill_d  = !i_imem_resp_valid;
            state_d = ST_FAULT;
          end else if (i_imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (i_imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (i_imem_resp_err) begin
            ir_d    = NOP_W;
            fpc_d   = pc_q;
            state_d = ST_FAULT;
          end else begin
            ir_d    = i_imem_resp_data;
            fpc_d   = pc_q;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD, ST_FAULT: begin
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc;
          if (mis) begin
            ir_d    = NOP_W;
            fpc_d   = i_redirect_pc;
            state_d = ST_FAULT;
          end else begin
            state_d = ST_REQ;
          end
        end else if (state_q == ST_HOLD && i_decode_ready) begin
          pc_d    = pc_q + WORD_SIZE'(4);
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      fpc_q   <= RESET_PC;
      ir_q    <= NOP_W;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      ir_q    <= ir_d;
      kill_q  <= kill_d;
    end
  end

  assign o_imem_req_valid    = state_q == ST_REQ;
  assign o_imem_addr         = pc_q;
  assign o_fetch_valid       = (state_q == ST_HOLD) ||
                               (state_q == ST_FAULT);
  assign o_fetch_fault       = state_q == ST_FAULT;
  assign o_fetch_instruction = ir_q;
  assign o_fetch_pc          = fpc_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed scoreboard bench for rv32i_fetch_unit.
// Expected fetches are queued when responses are driven, popped on valid.
module tb_rv32i_fetch_unit;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_resp_valid;
  logic [31:0] i_imem_resp_data;
  logic        i_imem_resp_err;
  logic        o_fetch_valid;
  logic        i_decode_ready;
  logic [31:0] o_fetch_instruction;
  logic [31:0] o_fetch_pc;
  logic        o_fetch_fault;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;

  rv32i_fetch_unit dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .o_imem_req_valid    (o_imem_req_valid),
    .i_imem_req_ready    (i_imem_req_ready),
    .o_imem_addr         (o_imem_addr),
    .i_imem_resp_valid   (i_imem_resp_valid),
    .i_imem_resp_data    (i_imem_resp_data),
    .i_imem_resp_err     (i_imem_resp_err),
    .o_fetch_valid       (o_fetch_valid),
    .i_decode_ready      (i_decode_ready),
    .o_fetch_instruction (o_fetch_instruction),
    .o_fetch_pc          (o_fetch_pc),
    .o_fetch_fault       (o_fetch_fault),
    .i_redirect_valid    (i_redirect_valid),
    .i_redirect_pc       (i_redirect_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    while (!o_imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, o_imem_req_valid}, 32'd1);
    chk("req_addr", o_imem_addr, addr);
  endtask

  task automatic mem_xact(input logic [31:0] data, input logic err);
    i_imem_req_ready = 1'b1;
    tick();
    i_imem_req_ready  = 1'b0;
    i_imem_resp_valid = 1'b1;
    i_imem_resp_data  = data;
    i_imem_resp_err   = err;
    tick();
    i_imem_resp_valid = 1'b0;
    i_imem_resp_err   = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    exp_t e;
    while (!o_fetch_valid && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_seen", {31'd0, o_fetch_valid}, 32'd1);
    chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("fetch_instr", o_fetch_instruction, e.instr);
      chk("fetch_pc", o_fetch_pc, e.pc);
      chk("fetch_fault", {31'd0, o_fetch_fault}, {31'd0, e.fault});
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = pc;
    tick();
    i_redirect_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_imem_req_ready = 1'b0;
    i_imem_resp_valid = 1'b0;
    i_imem_resp_data = 32'd0;
    i_imem_resp_err = 1'b0;
    i_decode_ready = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc = 32'd0;
    tick();
    tick();
    chk("rst_req", {31'd0, o_imem_req_valid}, 32'd0);
    chk("rst_fv", {31'd0, o_fetch_valid}, 32'd0);
    chk("rst_fault", {31'd0, o_fetch_fault}, 32'd0);
    chk("rst_addr", o_imem_addr, 32'h0);
    i_rst = 1'b0;
    chk("post_rst_req", {31'd0, o_imem_req_valid}, 32'd0);
    chk("post_rst_fv", {31'd0, o_fetch_valid}, 32'd0);

    // basic fetch and sequential advance
    wait_req(32'h0);
    sb.push_back('{32'h0050_0093, 32'h0, 1'b0});
    mem_xact(32'h0050_0093, 1'b0);
    wait_fetch();
    i_decode_ready = 1'b1;
    tick();
    i_decode_ready = 1'b0;
    wait_req(32'h4);

    // redirect while waiting kills the late response
    i_imem_req_ready = 1'b1;
    tick();
    i_imem_req_ready = 1'b0;
    redirect(32'h100);
    tick();
    i_imem_resp_valid = 1'b1;
    i_imem_resp_data = 32'hDEAD_BEEF;
    tick();
    i_imem_resp_valid = 1'b0;
    chk("kill_fv", {31'd0, o_fetch_valid}, 32'd0);
    wait_req(32'h100);

    // decode stall holds the presented instruction
    sb.push_back('{32'h1111_1111, 32'h100, 1'b0});
    mem_xact(32'h1111_1111, 1'b0);
    wait_fetch();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_fv", {31'd0, o_fetch_valid}, 32'd1);
      chk("hold_instr", o_fetch_instruction, 32'h1111_1111);
      chk("hold_pc", o_fetch_pc, 32'h100);
      chk("hold_noreq", {31'd0, o_imem_req_valid}, 32'd0);
    end
    i_decode_ready = 1'b1;
    tick();
    i_decode_ready = 1'b0;
    wait_req(32'h104);

    // redirect in REQ without handshake stays in REQ
    redirect(32'h8);
    chk("req_redir_v", {31'd0, o_imem_req_valid}, 32'd1);
    chk("req_redir_a", o_imem_addr, 32'h8);

    // bus error becomes a sticky fault until redirected
    sb.push_back('{32'h0000_0013, 32'h8, 1'b1});
    mem_xact(32'hCAFE_F00D, 1'b1);
    wait_fetch();
    i_decode_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flt_fv", {31'd0, o_fetch_valid}, 32'd1);
      chk("flt_fault", {31'd0, o_fetch_fault}, 32'd1);
      chk("flt_pc", o_fetch_pc, 32'h8);
      chk("flt_noreq", {31'd0, o_imem_req_valid}, 32'd0);
    end
    redirect(32'h20);
    i_decode_ready = 1'b0;
    chk("flt_exit_fv", {31'd0, o_fetch_valid}, 32'd0);
    wait_req(32'h20);

    // misaligned redirect target
    sb.push_back('{32'h0000_0013, 32'h102, 1'b1});
    redirect(32'h102);
    wait_fetch();
    chk("mis_noreq", {31'd0, o_imem_req_valid}, 32'd0);

    // pc wraps at the top of the address space
    redirect(32'hFFFF_FFFC);
    wait_req(32'hFFFF_FFFC);
    sb.push_back('{32'h2222_2222, 32'hFFFF_FFFC, 1'b0});
    mem_xact(32'h2222_2222, 1'b0);
    wait_fetch();
    i_decode_ready = 1'b1;
    tick();
    i_decode_ready = 1'b0;
    wait_req(32'h0);

    // redirect coincident with handshake
    i_imem_req_ready = 1'b1;
    redirect(32'h40);
    i_imem_req_ready = 1'b0;
    i_imem_resp_valid = 1'b1;
    i_imem_resp_data = 32'h3333_3333;
    tick();
    i_imem_resp_valid = 1'b0;
    chk("hs_redir_fv", {31'd0, o_fetch_valid}, 32'd0);
    wait_req(32'h40);

    // redirect in HOLD overrides decode_ready
    sb.push_back('{32'h4444_4444, 32'h40, 1'b0});
    mem_xact(32'h4444_4444, 1'b0);
    wait_fetch();
    i_decode_ready = 1'b1;
    redirect(32'h80);
    i_decode_ready = 1'b0;
    chk("hold_redir_fv", {31'd0, o_fetch_valid}, 32'd0);
    wait_req(32'h80);

    // reset mid-transaction, late response ignored
    i_imem_req_ready = 1'b1;
    tick();
    i_imem_req_ready = 1'b0;
    i_rst = 1'b1;
    tick();
    chk("mid_rst_req", {31'd0, o_imem_req_valid}, 32'd0);
    chk("mid_rst_addr", o_imem_addr, 32'h0);
    i_rst = 1'b0;
    i_imem_resp_valid = 1'b1;
    i_imem_resp_data = 32'h5555_5555;
    tick();
    i_imem_resp_valid = 1'b0;
    chk("late_fv", {31'd0, o_fetch_valid}, 32'd0);
    wait_req(32'h0);

    // redirect in WAIT with same-cycle response
    i_imem_req_ready = 1'b1;
    tick();
    i_imem_req_ready = 1'b0;
    i_imem_resp_valid = 1'b1;
    i_imem_resp_data = 32'h6666_6666;
    redirect(32'h200);
    i_imem_resp_valid = 1'b0;
    chk("wait_redir_fv", {31'd0, o_fetch_valid}, 32'd0);
    chk("wait_redir_req", {31'd0, o_imem_req_valid}, 32'd1);
    chk("wait_redir_a", o_imem_addr, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
